// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the decode->execute pipeline register.
//   REG_OP_*     : destination register class carried down the pipe
//   WB_DATA_OP_* : writeback data source selector
//   DATA_ZERO    : zero word of the core data width
//   CTRL_*       : bit offsets/widths of the packed execute/memory control word
package id_ex_stage_pkg;

  localparam int unsigned CORE_DATA_W = 16;

  localparam logic [CORE_DATA_W-1:0] DATA_ZERO = '0;

  // Destination register class.
  localparam logic [2:0] REG_OP_NOP = 3'd0;
  localparam logic [2:0] REG_OP_REG = 3'd1;
  localparam logic [2:0] REG_OP_IH  = 3'd2;
  localparam logic [2:0] REG_OP_SP  = 3'd3;
  localparam logic [2:0] REG_OP_T   = 3'd4;

  // Writeback data source.
  localparam logic [2:0] WB_DATA_OP_NOP = 3'd0;
  localparam logic [2:0] WB_DATA_OP_ALU = 3'd1;
  localparam logic [2:0] WB_DATA_OP_MEM = 3'd2;
  localparam logic [2:0] WB_DATA_OP_IH  = 3'd3;
  localparam logic [2:0] WB_DATA_OP_PC  = 3'd4;

  // Packed control word layout: {mem_wr, mem_rd, op2_sel, op1_sel, alu_op}.
  localparam int unsigned CTRL_ALU_OP_LSB  = 0;
  localparam int unsigned CTRL_ALU_OP_W    = 4;
  localparam int unsigned CTRL_OP1_SEL_LSB = 4;
  localparam int unsigned CTRL_OP1_SEL_W   = 3;
  localparam int unsigned CTRL_OP2_SEL_LSB = 7;
  localparam int unsigned CTRL_OP2_SEL_W   = 3;
  localparam int unsigned CTRL_MEM_RD_BIT  = 10;
  localparam int unsigned CTRL_MEM_WR_BIT  = 11;

  // Register update decision taken each clock edge.
  typedef enum logic [1:0] {
    UpdAdvance,
    UpdHold,
    UpdBubble,
    UpdLoadUse
  } upd_e;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection.
// Flags when the instruction held in execute is a load into a general
// register and the instruction in decode reads that register.
//   ex_valid_i, ex_wb_data_op_i, ex_reg_op_i, ex_wb_addr_i : execute slot state
//   id_valid_i, id_reg{1,2}_addr_i, id_reg{1,2}_used_i     : decode slot sources
//   load_use_stall_o                                       : hazard present
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  ex_valid_i,
  input  logic [2:0]            ex_wb_data_op_i,
  input  logic [2:0]            ex_reg_op_i,
  input  logic [REG_ADDR_W-1:0] ex_wb_addr_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
  input  logic                  id_reg1_used_i,
  input  logic                  id_reg2_used_i,
  output logic                  load_use_stall_o
);

  logic ex_is_load;
  logic src_match;

  assign ex_is_load = ex_valid_i && (ex_wb_data_op_i == WB_DATA_OP_MEM) &&
                      (ex_reg_op_i == REG_OP_REG);

  assign src_match = (id_reg1_used_i && (id_reg1_addr_i == ex_wb_addr_i)) ||
                     (id_reg2_used_i && (id_reg2_addr_i == ex_wb_addr_i));

  assign load_use_stall_o = ex_is_load && id_valid_i && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register of the 16-bit 5-stage core.
// Captures decoded fields, selects forwarded or register-file operands,
// inserts a bubble on load-use hazards (requesting an upstream stall),
// honours stall/flush and counts injected load-use bubbles (saturating).
//   clk, rst (async, active low)
//   id_*                   : decoded instruction fields
//   reg{1,2}_forward_*     : forwarding enable/data pairs
//   stall, flush           : global pipeline control
//   ex_*                   : registered execute-stage fields
//   load_use_stall         : combinational upstream hold request
//   bubble_count           : saturating load-use bubble counter
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned CTRL_W     = 12,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [DATA_W-1:0]     id_reg1_data,
  input  logic [DATA_W-1:0]     id_reg2_data,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr,
  input  logic                  id_reg1_used,
  input  logic                  id_reg2_used,
  input  logic [REG_ADDR_W-1:0] id_wb_addr,
  input  logic [2:0]            id_reg_op,
  input  logic [2:0]            id_wb_data_op,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  reg1_forward_enable,
  input  logic [DATA_W-1:0]     reg1_forward_data,
  input  logic                  reg2_forward_enable,
  input  logic [DATA_W-1:0]     reg2_forward_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [DATA_W-1:0]     ex_reg1_data,
  output logic [DATA_W-1:0]     ex_reg2_data,
  output logic [REG_ADDR_W-1:0] ex_wb_addr,
  output logic [2:0]            ex_reg_op,
  output logic [2:0]            ex_wb_data_op,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic                  load_use_stall,
  output logic [CNT_W-1:0]      bubble_count
);

  localparam logic [DATA_W-1:0] Zero = DATA_W'(DATA_ZERO);

  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [DATA_W-1:0]     reg1_q, reg1_d;
  logic [DATA_W-1:0]     reg2_q, reg2_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [2:0]            reg_op_q, reg_op_d;
  logic [2:0]            wb_op_q, wb_op_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [CNT_W-1:0]      bub_cnt_q, bub_cnt_d;

  logic hazard;
  upd_e upd;

  id_ex_stage_hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .ex_valid_i      (valid_q),
    .ex_wb_data_op_i (wb_op_q),
    .ex_reg_op_i     (reg_op_q),
    .ex_wb_addr_i    (wb_addr_q),
    .id_valid_i      (id_valid),
    .id_reg1_addr_i  (id_reg1_addr),
    .id_reg2_addr_i  (id_reg2_addr),
    .id_reg1_used_i  (id_reg1_used),
    .id_reg2_used_i  (id_reg2_used),
    .load_use_stall_o(hazard)
  );

  // Flush beats everything; a load-use bubble only happens while not stalled.
  always_comb begin
    upd = UpdAdvance;
    if (flush) begin
      upd = UpdBubble;
    end else if (hazard && !stall) begin
      upd = UpdLoadUse;
    end else if (stall) begin
      upd = UpdHold;
    end else if (!id_valid) begin
      // A not-valid slot must never carry a register write downstream.
      upd = UpdBubble;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;
    wb_addr_d = wb_addr_q;
    reg_op_d  = reg_op_q;
    wb_op_d   = wb_op_q;
    ctrl_d    = ctrl_q;
    bub_cnt_d = bub_cnt_q;
    unique case (upd)
      UpdBubble, UpdLoadUse: begin
        valid_d   = 1'b0;
        pc_d      = Zero;
        imm_d     = Zero;
        reg1_d    = Zero;
        reg2_d    = Zero;
        wb_addr_d = '0;
        reg_op_d  = REG_OP_NOP;
        wb_op_d   = WB_DATA_OP_NOP;
        ctrl_d    = '0;
        if (upd == UpdLoadUse && bub_cnt_q != '1) begin
          bub_cnt_d = bub_cnt_q + CNT_W'(1);
        end
      end
      UpdAdvance: begin
        valid_d   = 1'b1;
        pc_d      = id_pc;
        imm_d     = id_imm;
        reg1_d    = reg1_forward_enable ? reg1_forward_data : id_reg1_data;
        reg2_d    = reg2_forward_enable ? reg2_forward_data : id_reg2_data;
        wb_addr_d = id_wb_addr;
        reg_op_d  = id_reg_op;
        wb_op_d   = id_wb_data_op;
        ctrl_d    = id_ctrl;
      end
      default: ;  // UpdHold keeps every field
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      pc_q      <= Zero;
      imm_q     <= Zero;
      reg1_q    <= Zero;
      reg2_q    <= Zero;
      wb_addr_q <= '0;
      reg_op_q  <= REG_OP_NOP;
      wb_op_q   <= WB_DATA_OP_NOP;
      ctrl_q    <= '0;
      bub_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      wb_addr_q <= wb_addr_d;
      reg_op_q  <= reg_op_d;
      wb_op_q   <= wb_op_d;
      ctrl_q    <= ctrl_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_pc          = pc_q;
  assign ex_imm         = imm_q;
  assign ex_reg1_data   = reg1_q;
  assign ex_reg2_data   = reg2_q;
  assign ex_wb_addr     = wb_addr_q;
  assign ex_reg_op      = reg_op_q;
  assign ex_wb_data_op  = wb_op_q;
  assign ex_ctrl        = ctrl_q;
  assign load_use_stall = hazard;
  assign bubble_count   = bub_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for the advance/forwarding path,
// hand-written sequences for reset, load-use, stall, flush and saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [15:0] id_pc, id_imm, id_reg1_data, id_reg2_data;
  logic [3:0]  id_reg1_addr, id_reg2_addr, id_wb_addr;
  logic        id_reg1_used, id_reg2_used;
  logic [2:0]  id_reg_op, id_wb_data_op;
  logic [11:0] id_ctrl;
  logic        reg1_forward_enable, reg2_forward_enable;
  logic [15:0] reg1_forward_data, reg2_forward_data;
  logic        stall, flush;

  logic        ex_valid;
  logic [15:0] ex_pc, ex_imm, ex_reg1_data, ex_reg2_data;
  logic [3:0]  ex_wb_addr;
  logic [2:0]  ex_reg_op, ex_wb_data_op;
  logic [11:0] ex_ctrl;
  logic        load_use_stall;
  logic [15:0] bubble_count;

  // Narrow-counter copy, used only to observe saturation in reasonable time.
  logic        s_valid;
  logic [15:0] s_pc, s_imm, s_r1, s_r2;
  logic [3:0]  s_wb_addr;
  logic [2:0]  s_reg_op, s_wb_op;
  logic [11:0] s_ctrl;
  logic        s_lus;
  logic [2:0]  s_count;

  int errors = 0;
  int checks = 0;
  int exp_bub = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_reg1_data(id_reg1_data), .id_reg2_data(id_reg2_data),
    .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_reg1_used(id_reg1_used), .id_reg2_used(id_reg2_used), .id_wb_addr(id_wb_addr),
    .id_reg_op(id_reg_op), .id_wb_data_op(id_wb_data_op), .id_ctrl(id_ctrl),
    .reg1_forward_enable(reg1_forward_enable), .reg1_forward_data(reg1_forward_data),
    .reg2_forward_enable(reg2_forward_enable), .reg2_forward_data(reg2_forward_data),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_reg1_data(ex_reg1_data), .ex_reg2_data(ex_reg2_data), .ex_wb_addr(ex_wb_addr),
    .ex_reg_op(ex_reg_op), .ex_wb_data_op(ex_wb_data_op), .ex_ctrl(ex_ctrl),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  id_ex_stage #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_reg1_data(id_reg1_data), .id_reg2_data(id_reg2_data),
    .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_reg1_used(id_reg1_used), .id_reg2_used(id_reg2_used), .id_wb_addr(id_wb_addr),
    .id_reg_op(id_reg_op), .id_wb_data_op(id_wb_data_op), .id_ctrl(id_ctrl),
    .reg1_forward_enable(reg1_forward_enable), .reg1_forward_data(reg1_forward_data),
    .reg2_forward_enable(reg2_forward_enable), .reg2_forward_data(reg2_forward_data),
    .stall(stall), .flush(flush), .ex_valid(s_valid), .ex_pc(s_pc), .ex_imm(s_imm),
    .ex_reg1_data(s_r1), .ex_reg2_data(s_r2), .ex_wb_addr(s_wb_addr),
    .ex_reg_op(s_reg_op), .ex_wb_data_op(s_wb_op), .ex_ctrl(s_ctrl),
    .load_use_stall(s_lus), .bubble_count(s_count)
  );

  typedef struct {
    logic        valid;
    logic [15:0] pc, imm, r1, r2;
    logic        fe1;
    logic [15:0] fd1;
    logic        fe2;
    logic [15:0] fd2;
    logic [3:0]  wb_addr;
    logic [2:0]  reg_op, wb_op;
    logic [11:0] ctrl;
    logic        x_valid;
    logic [15:0] x_pc, x_imm, x_r1, x_r2;
    logic [3:0]  x_wb_addr;
    logic [2:0]  x_reg_op, x_wb_op;
    logic [11:0] x_ctrl;
  } vec_t;

  vec_t tv [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_imm = 0; id_reg1_data = 0; id_reg2_data = 0;
    id_reg1_addr = 0; id_reg2_addr = 0; id_reg1_used = 0; id_reg2_used = 0;
    id_wb_addr = 0; id_reg_op = 0; id_wb_data_op = 0; id_ctrl = 0;
    reg1_forward_enable = 0; reg1_forward_data = 0;
    reg2_forward_enable = 0; reg2_forward_data = 0;
  endtask

  // Advance a load (MEM -> general register) into execute.
  task automatic do_lw(input logic [3:0] dst, input logic [15:0] pc);
    idle_inputs();
    id_valid = 1; id_pc = pc; id_wb_addr = dst; id_reg_op = 3'd1; id_wb_data_op = 3'd2;
    tick();
  endtask

  // Present an ALU instruction in decode that reads register src on operand sel.
  task automatic present_dep(input int sel, input logic [3:0] src, input logic [15:0] pc);
    idle_inputs();
    id_valid = 1; id_pc = pc; id_wb_addr = 4'd9; id_reg_op = 3'd1; id_wb_data_op = 3'd1;
    if (sel == 1) begin id_reg1_addr = src; id_reg1_used = 1; end
    else begin id_reg2_addr = src; id_reg2_used = 1; end
  endtask

  initial begin
    rst = 0; stall = 0; flush = 0;
    idle_inputs();

    //              valid pc      imm     r1      r2      fe1 fd1     fe2 fd2
    //              wb  rop   wop   ctrl    | expected fields
    tv[0] = '{1, 16'h0040, 16'h0005, 16'h1111, 16'h2222, 1, 16'hBEEF, 0, 16'h0000,
              4'd5, 3'd1, 3'd1, 12'h123,
              1, 16'h0040, 16'h0005, 16'hBEEF, 16'h2222, 4'd5, 3'd1, 3'd1, 12'h123};
    tv[1] = '{1, 16'h0042, 16'h0006, 16'h1111, 16'h2222, 0, 16'hBEEF, 1, 16'hCAFE,
              4'd6, 3'd2, 3'd3, 12'h456,
              1, 16'h0042, 16'h0006, 16'h1111, 16'hCAFE, 4'd6, 3'd2, 3'd3, 12'h456};
    tv[2] = '{1, 16'h0044, 16'h7FFF, 16'h1234, 16'h5678, 1, 16'hAAAA, 1, 16'h5555,
              4'd0, 3'd3, 3'd1, 12'h800,
              1, 16'h0044, 16'h7FFF, 16'hAAAA, 16'h5555, 4'd0, 3'd3, 3'd1, 12'h800};
    tv[3] = '{0, 16'h0046, 16'h0009, 16'h3333, 16'h4444, 1, 16'h9999, 0, 16'h0000,
              4'd7, 3'd1, 3'd1, 12'h0FF,
              0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd0, 3'd0, 3'd0, 12'h000};
    tv[4] = '{1, 16'hFFFF, 16'h8000, 16'h0001, 16'hFFFE, 0, 16'h0000, 0, 16'h0000,
              4'd15, 3'd4, 3'd4, 12'hFFF,
              1, 16'hFFFF, 16'h8000, 16'h0001, 16'hFFFE, 4'd15, 3'd4, 3'd4, 12'hFFF};

    // Reset state.
    #1;
    chk("reset_valid", 32'(ex_valid), 0);
    chk("reset_pc", 32'(ex_pc), 0);
    chk("reset_reg_op", 32'(ex_reg_op), 0);
    chk("reset_wb_op", 32'(ex_wb_data_op), 0);
    chk("reset_count", 32'(bubble_count), 0);
    #2 rst = 1;

    // Advance / forwarding table.
    for (int i = 0; i < 5; i++) begin
      id_valid = tv[i].valid; id_pc = tv[i].pc; id_imm = tv[i].imm;
      id_reg1_data = tv[i].r1; id_reg2_data = tv[i].r2;
      reg1_forward_enable = tv[i].fe1; reg1_forward_data = tv[i].fd1;
      reg2_forward_enable = tv[i].fe2; reg2_forward_data = tv[i].fd2;
      id_wb_addr = tv[i].wb_addr; id_reg_op = tv[i].reg_op;
      id_wb_data_op = tv[i].wb_op; id_ctrl = tv[i].ctrl;
      id_reg1_used = 0; id_reg2_used = 0;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(tv[i].x_valid));
      chk($sformatf("vec%0d_pc", i), 32'(ex_pc), 32'(tv[i].x_pc));
      chk($sformatf("vec%0d_imm", i), 32'(ex_imm), 32'(tv[i].x_imm));
      chk($sformatf("vec%0d_r1", i), 32'(ex_reg1_data), 32'(tv[i].x_r1));
      chk($sformatf("vec%0d_r2", i), 32'(ex_reg2_data), 32'(tv[i].x_r2));
      chk($sformatf("vec%0d_wb_addr", i), 32'(ex_wb_addr), 32'(tv[i].x_wb_addr));
      chk($sformatf("vec%0d_reg_op", i), 32'(ex_reg_op), 32'(tv[i].x_reg_op));
      chk($sformatf("vec%0d_wb_op", i), 32'(ex_wb_data_op), 32'(tv[i].x_wb_op));
      chk($sformatf("vec%0d_ctrl", i), 32'(ex_ctrl), 32'(tv[i].x_ctrl));
    end

    // Load-use on source 2: bubble, count, then dependent advances.
    do_lw(4'd3, 16'h0100);
    present_dep(2, 4'd3, 16'h0102);
    #1 chk("lu2_stall", 32'(load_use_stall), 1);
    tick();
    exp_bub++;
    chk("lu2_bubble_valid", 32'(ex_valid), 0);
    chk("lu2_bubble_pc", 32'(ex_pc), 0);
    chk("lu2_count", 32'(bubble_count), 32'(exp_bub));
    chk("lu2_stall_after", 32'(load_use_stall), 0);
    tick();
    chk("lu2_adv_valid", 32'(ex_valid), 1);
    chk("lu2_adv_pc", 32'(ex_pc), 32'h0102);

    // Load-use on source 1.
    do_lw(4'd5, 16'h0110);
    present_dep(1, 4'd5, 16'h0112);
    #1 chk("lu1_stall", 32'(load_use_stall), 1);
    tick();
    exp_bub++;
    chk("lu1_count", 32'(bubble_count), 32'(exp_bub));

    // No false hazard: source not used.
    do_lw(4'd3, 16'h0120);
    present_dep(2, 4'd3, 16'h0122);
    id_reg2_used = 0;
    #1 chk("nf_unused_stall", 32'(load_use_stall), 0);
    tick();
    chk("nf_unused_pc", 32'(ex_pc), 32'h0122);
    chk("nf_unused_count", 32'(bubble_count), 32'(exp_bub));

    // No false hazard: producer is ALU, not a load.
    idle_inputs();
    id_valid = 1; id_pc = 16'h0130; id_wb_addr = 4'd3; id_reg_op = 3'd1; id_wb_data_op = 3'd1;
    tick();
    present_dep(2, 4'd3, 16'h0132);
    #1 chk("nf_alu_stall", 32'(load_use_stall), 0);
    tick();
    chk("nf_alu_pc", 32'(ex_pc), 32'h0132);

    // No false hazard: address mismatch.
    do_lw(4'd3, 16'h0140);
    present_dep(1, 4'd4, 16'h0142);
    #1 chk("nf_addr_stall", 32'(load_use_stall), 0);
    tick();

    // Stall 3 cycles while decode changes.
    idle_inputs();
    id_valid = 1; id_pc = 16'h0300; id_imm = 16'h0033; id_wb_data_op = 3'd1;
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc = 16'h0310 + 16'(i); id_imm = 16'h0400 + 16'(i);
      tick();
      chk($sformatf("stall%0d_pc", i), 32'(ex_pc), 32'h0300);
      chk($sformatf("stall%0d_imm", i), 32'(ex_imm), 32'h0033);
    end
    stall = 0; id_pc = 16'h0400; id_imm = 16'h0044;
    tick();
    chk("unstall_pc", 32'(ex_pc), 32'h0400);
    chk("unstall_imm", 32'(ex_imm), 32'h0044);

    // Stall with load-use pending: hold, no count; bubble once released.
    do_lw(4'd7, 16'h0200);
    present_dep(1, 4'd7, 16'h0202);
    stall = 1;
    tick();
    chk("stall_lu_pc", 32'(ex_pc), 32'h0200);
    chk("stall_lu_count", 32'(bubble_count), 32'(exp_bub));
    chk("stall_lu_stall", 32'(load_use_stall), 1);
    stall = 0;
    tick();
    exp_bub++;
    chk("stall_lu_rel_valid", 32'(ex_valid), 0);
    chk("stall_lu_rel_count", 32'(bubble_count), 32'(exp_bub));

    // Flush + stall + load-use: bubble, no count.
    do_lw(4'd3, 16'h0210);
    present_dep(2, 4'd3, 16'h0212);
    stall = 1; flush = 1;
    #1 chk("flush_lu_stall", 32'(load_use_stall), 1);
    tick();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_pc", 32'(ex_pc), 0);
    chk("flush_count", 32'(bubble_count), 32'(exp_bub));
    stall = 0; flush = 0;

    // Saturation on the narrow counter; wide counter keeps counting.
    for (int i = 0; i < 10; i++) begin
      do_lw(4'd2, 16'h0500);
      present_dep(1, 4'd2, 16'h0502);
      tick();
      exp_bub++;
    end
    chk("count_after_burst", 32'(bubble_count), 32'(exp_bub));
    chk("sat_count", 32'(s_count), 7);

    // Asynchronous reset mid-stall.
    idle_inputs();
    id_valid = 1; id_pc = 16'h0600;
    tick();
    stall = 1;
    tick();
    #2 rst = 0;
    #1;
    chk("areset_valid", 32'(ex_valid), 0);
    chk("areset_pc", 32'(ex_pc), 0);
    chk("areset_count", 32'(bubble_count), 0);
    chk("areset_sat_count", 32'(s_count), 0);
    #1 rst = 1;
    stall = 0; id_valid = 1; id_pc = 16'h0040;
    tick();
    chk("post_reset_pc", 32'(ex_pc), 32'h0040);
    chk("post_reset_valid", 32'(ex_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
